// File: rtl/vector_mac_engine.sv
// Multi-lane, multi-cycle vector multiply / dot-product engine with valid/ready
// handshakes and a saturating accumulate mode that chains dot products.
module vector_mac_engine #(
  parameter int unsigned ELEMENT_SIZE = 16,
  parameter int unsigned VECTOR_SIZE  = 20,
  parameter int unsigned LANES        = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         clear,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic                                         accumulate,
  input  logic [ELEMENT_SIZE*VECTOR_SIZE-1:0]          vector_a,
  input  logic [ELEMENT_SIZE*VECTOR_SIZE-1:0]          vector_b,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [2*ELEMENT_SIZE*VECTOR_SIZE-1:0]        result,
  output logic [2*ELEMENT_SIZE+$clog2(VECTOR_SIZE)-1:0] dot_product,
  output logic                                         overflow
);

  localparam int unsigned PROD_SIZE = 2 * ELEMENT_SIZE;
  localparam int unsigned ACC_SIZE  = PROD_SIZE + $clog2(VECTOR_SIZE);
  localparam int unsigned BEATS     = VECTOR_SIZE / LANES;
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned VEC_W     = ELEMENT_SIZE * VECTOR_SIZE;
  localparam int unsigned LANE_W    = ELEMENT_SIZE * LANES;

  generate
    if ((VECTOR_SIZE % LANES) != 0) begin : g_bad_lanes
      $error("vector_mac_engine: LANES must divide VECTOR_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                                   r_state;
  state_t                                   w_next_state;
  logic [BEAT_W-1:0]                        r_beat;
  logic [VEC_W-1:0]                         r_a;
  logic [VEC_W-1:0]                         r_b;
  logic [VECTOR_SIZE-1:0][PROD_SIZE-1:0]    r_result;
  logic [ACC_SIZE-1:0]                      r_acc;
  logic                                     r_ovf;

  logic                                     w_in_ready;
  logic                                     w_out_valid;
  logic                                     w_last_beat;
  logic [PROD_SIZE-1:0]                     w_prod [LANES];
  logic [ACC_SIZE-1:0]                      w_lane_sum;
  logic [ACC_SIZE:0]                        w_acc_sum;
  logic                                     w_sat;

  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; clear wins over both handshakes
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (in_valid)    w_next_state = S_COMPUTE;
        S_COMPUTE: if (w_last_beat) w_next_state = S_DONE;
        S_DONE:    if (out_ready)   w_next_state = S_IDLE;
        default:                    w_next_state = S_IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Lane multipliers read the low LANES elements of the shifting operand registers
  always_comb begin
    w_lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_prod[l]  = PROD_SIZE'(r_a[l*ELEMENT_SIZE +: ELEMENT_SIZE]) *
                   PROD_SIZE'(r_b[l*ELEMENT_SIZE +: ELEMENT_SIZE]);
      w_lane_sum = w_lane_sum + ACC_SIZE'(w_prod[l]);
    end
  end

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_lane_sum};
  assign w_sat     = w_acc_sum[ACC_SIZE];

  // Datapath: operand capture, per-beat product write-back and saturating accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      r_beat   <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= vector_a;
            r_b    <= vector_b;
            r_beat <= '0;
            if (!accumulate) begin
              r_acc <= '0;
              r_ovf <= 1'b0;
            end
          end
        end
        S_COMPUTE: begin
          for (int s = 0; s < VECTOR_SIZE; s++) begin
            if (r_beat == BEAT_W'(s / LANES)) begin
              r_result[s] <= w_prod[s % LANES];
            end
          end
          if (w_sat) begin
            r_acc <= '1;
            r_ovf <= 1'b1;
          end else begin
            r_acc <= w_acc_sum[ACC_SIZE-1:0];
          end
          r_beat <= r_beat + 1'b1;
          r_a    <= r_a >> LANE_W;
          r_b    <= r_b >> LANE_W;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready & ~rst;
  assign out_valid   = w_out_valid;
  assign result      = r_result;
  assign dot_product = r_acc;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_vector_mac_engine.sv
// Directed self-checking bench for vector_mac_engine: main instance at LANES=4
// plus LANES=1 and LANES=20 instances for the latency sweep.
module tb_vector_mac_engine;

  localparam int unsigned ES = 16;
  localparam int unsigned VS = 20;
  localparam int unsigned PS = 32;
  localparam int unsigned AS = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clear, in_valid, accumulate, out_ready;
  logic [ES*VS-1:0] vector_a, vector_b;
  logic             in_ready, out_valid, overflow;
  logic [PS*VS-1:0] result;
  logic [AS-1:0]    dot_product;

  logic             sw_in_valid, sw_out_ready;
  logic             l1_in_ready, l1_out_valid, l1_overflow;
  logic [PS*VS-1:0] l1_result;
  logic [AS-1:0]    l1_dot;
  logic             l20_in_ready, l20_out_valid, l20_overflow;
  logic [PS*VS-1:0] l20_result;
  logic [AS-1:0]    l20_dot;

  int errors = 0;
  int checks = 0;

  vector_mac_engine #(.ELEMENT_SIZE(ES), .VECTOR_SIZE(VS), .LANES(4)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .accumulate(accumulate), .vector_a(vector_a), .vector_b(vector_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .dot_product(dot_product), .overflow(overflow));

  vector_mac_engine #(.ELEMENT_SIZE(ES), .VECTOR_SIZE(VS), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(sw_in_valid), .in_ready(l1_in_ready),
    .accumulate(accumulate), .vector_a(vector_a), .vector_b(vector_b),
    .out_valid(l1_out_valid), .out_ready(sw_out_ready), .result(l1_result),
    .dot_product(l1_dot), .overflow(l1_overflow));

  vector_mac_engine #(.ELEMENT_SIZE(ES), .VECTOR_SIZE(VS), .LANES(20)) u_l20 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(sw_in_valid), .in_ready(l20_in_ready),
    .accumulate(accumulate), .vector_a(vector_a), .vector_b(vector_b),
    .out_valid(l20_out_valid), .out_ready(sw_out_ready), .result(l20_result),
    .dot_product(l20_dot), .overflow(l20_overflow));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ES*VS-1:0] ramp();
    logic [ES*VS-1:0] v;
    for (int i = 0; i < VS; i++) v[i*ES +: ES] = ES'(i + 1);
    return v;
  endfunction

  function automatic logic [ES*VS-1:0] fill(input logic [ES-1:0] val);
    logic [ES*VS-1:0] v;
    for (int i = 0; i < VS; i++) v[i*ES +: ES] = val;
    return v;
  endfunction

  // Called at a negedge with the engine idle; returns at the first negedge after the accept edge
  task automatic accept(input logic [ES*VS-1:0] a, input logic [ES*VS-1:0] b, input logic acc);
    vector_a   = a;
    vector_b   = b;
    accumulate = acc;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    vector_a   = ~a;
    vector_b   = ~b;
    accumulate = ~acc;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, l1_lat, l20_lat, seen;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; accumulate = 1'b0; out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b0;
    vector_a = '0; vector_b = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dot", 64'(dot_product), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_result_zero", 64'(result == '0), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Lane sweep: LANES=1 and LANES=20 instances on case 1
    vector_a = ramp(); vector_b = fill(16'd1); accumulate = 1'b0;
    sw_in_valid = 1'b1;
    @(negedge clk);
    sw_in_valid = 1'b0;
    l1_lat = -1; l20_lat = -1;
    for (int c = 0; c < 40; c++) begin
      if (l1_out_valid && l1_lat < 0) l1_lat = c;
      if (l20_out_valid && l20_lat < 0) l20_lat = c;
      @(negedge clk);
    end
    chk("l1_latency", 64'(l1_lat), 64'd20);
    chk("l20_latency", 64'(l20_lat), 64'd1);
    chk("l1_dot", 64'(l1_dot), 64'd210);
    chk("l20_dot", 64'(l20_dot), 64'd210);
    chk("l20_result19", 64'(l20_result[19*PS +: PS]), 64'd20);

    // Case 1: basic ramp times ones
    accept(ramp(), fill(16'd1), 1'b0);
    wait_done(lat);
    chk("c1_latency", 64'(lat), 64'd5);
    chk("c1_dot", 64'(dot_product), 64'd210);
    chk("c1_overflow", 64'(overflow), 64'd0);
    chk("c1_in_ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < VS; i++)
      chk($sformatf("c1_result%0d", i), 64'(result[i*PS +: PS]), 64'(i + 1));
    pop();
    chk("c1_out_valid_after_pop", 64'(out_valid), 64'd0);
    chk("c1_in_ready_after_pop", 64'(in_ready), 64'd1);

    // Non-saturating accumulate chain
    accept(ramp(), fill(16'd1), 1'b1);
    wait_done(lat);
    chk("acc_dot", 64'(dot_product), 64'd420);
    chk("acc_overflow", 64'(overflow), 64'd0);
    pop();

    // Case 2: all-max operands
    accept(fill(16'hFFFF), fill(16'hFFFF), 1'b0);
    wait_done(lat);
    chk("c2_dot", 64'(dot_product), 64'd85896724500);
    chk("c2_overflow", 64'(overflow), 64'd0);
    chk("c2_result0", 64'(result[0 +: PS]), 64'hFFFE0001);
    chk("c2_result19", 64'(result[19*PS +: PS]), 64'hFFFE0001);
    pop();

    // Case 3: accumulate saturates, then a fresh vector clears overflow
    accept(fill(16'hFFFF), fill(16'hFFFF), 1'b1);
    wait_done(lat);
    chk("c3_sat_dot", 64'(dot_product), 64'h1F_FFFF_FFFF);
    chk("c3_sat_overflow", 64'(overflow), 64'd1);
    pop();
    accept(ramp(), fill(16'd1), 1'b0);
    wait_done(lat);
    chk("c3_fresh_dot", 64'(dot_product), 64'd210);
    chk("c3_fresh_overflow", 64'(overflow), 64'd0);
    pop();

    // Case 4: backpressure in DONE, then back-to-back accept
    accept(ramp(), fill(16'd2), 1'b0);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_dot", 64'(dot_product), 64'd420);
      chk("bp_result19", 64'(result[19*PS +: PS]), 64'd40);
      vector_a = {VS{16'($urandom)}};
      @(negedge clk);
    end
    vector_a = ramp(); vector_b = fill(16'd1); accumulate = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_after_hs", 64'(in_ready), 64'd1);
    chk("bp_out_valid_after_hs", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_done(lat);
    chk("bp_next_latency", 64'(lat), 64'd5);
    chk("bp_next_dot", 64'(dot_product), 64'd210);
    pop();

    // Case 5: clear during beat 2 of an accumulate onto a saturated chain
    accept(fill(16'hFFFF), fill(16'hFFFF), 1'b0);
    wait_done(lat);
    pop();
    accept(fill(16'hFFFF), fill(16'hFFFF), 1'b1);
    wait_done(lat);
    chk("c5_pre_overflow", 64'(overflow), 64'd1);
    pop();
    accept(ramp(), fill(16'd1), 1'b1);
    @(negedge clk); @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    chk("clr_out_valid", 64'(out_valid), 64'd0);
    chk("clr_dot", 64'(dot_product), 64'd0);
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_result_zero", 64'(result == '0), 64'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1;
      @(negedge clk);
    end
    chk("clr_no_out_valid", 64'(seen), 64'd0);

    // Case 5b: asynchronous reset mid-compute
    accept(ramp(), fill(16'd1), 1'b0);
    @(negedge clk); @(negedge clk);
    chk("rst_mid_dot_nonzero", 64'(dot_product != '0), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_dot", 64'(dot_product), 64'd0);
    chk("arst_result_zero", 64'(result == '0), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_release_in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
